// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state, beat type and parameter checks for the matmul loop sequencer
package matmul_pkg;

    localparam int BEAT_ADDR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    typedef struct packed {
        logic                   first;
        logic                   last;
        logic [BEAT_ADDR_W-1:0] c_addr;
    } beat_t;

    // Largest matrix (MAX_DIM x MAX_DIM) must be addressable with addr_w bits
    function automatic bit addr_space_ok(input int unsigned max_dim, input int unsigned addr_w);
        return (64'(max_dim) * 64'(max_dim)) <= (64'd1 << addr_w);
    endfunction

endpackage

// File: rtl/matmul_beat_pipe.sv
// rtl/matmul_beat_pipe.sv - RD_LAT-deep valid+beat delay line aligning beat tags with operand data
module matmul_beat_pipe
    import matmul_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  out_valid,
    output beat_t out_beat,
    output logic  busy
);

    logic [DEPTH-1:0] vld;
    beat_t            stg [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                stg[s] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            stg[0] <= in_beat;
            for (int s = 1; s < DEPTH; s++) begin
                vld[s] <= vld[s-1];
                stg[s] <= stg[s-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_beat  = stg[DEPTH-1];
    assign busy      = |vld;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - i/j/k loop sequencer driving A/B reads, MAC strobes and C writes
// Optional cycle counter: define MATMUL_SEQ_PERF_EN to build perf_cycles.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int DIM_W   = 32,
    parameter int ADDR_W  = BEAT_ADDR_W,
    parameter int MAX_DIM = 256,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIM_W-1:0]  cfg_m,
    input  logic [DIM_W-1:0]  cfg_k,
    input  logic [DIM_W-1:0]  cfg_n,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic [ADDR_W-1:0] b_rd_addr,
    output logic              mac_en,
    output logic              mac_first,
    output logic              mac_last,
    output logic              c_wr_en,
    output logic [ADDR_W-1:0] c_wr_addr,
    output logic [31:0]       perf_cycles
);

    if (!addr_space_ok(MAX_DIM, ADDR_W) || ADDR_W > BEAT_ADDR_W || RD_LAT < 1) begin : g_bad_params
        $error("matmul_seq_ctrl: illegal parameter combination");
    end

    localparam logic [DIM_W-1:0]  D_ONE = DIM_W'(1);
    localparam logic [DIM_W-1:0]  D_TWO = DIM_W'(2);
    localparam logic [DIM_W-1:0]  D_MAX = DIM_W'(MAX_DIM);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    state_t            state;
    logic [DIM_W-1:0]  m_q, k_q, n_q;
    logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt;
    logic [ADDR_W-1:0] a_addr_q, a_row_q, b_addr_q, c_addr_q;
    logic              rd_en_q, first_q, last_q;

    logic              pipe_valid, pipe_busy;
    beat_t             beat_in, pipe_beat;

    logic              k_wrap, cfg_bad;

    assign k_wrap  = (k_cnt == k_q - D_ONE);
    assign cfg_bad = (m_q == '0) || (k_q == '0) || (n_q == '0) ||
                     (m_q > D_MAX) || (k_q > D_MAX) || (n_q > D_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            m_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            a_addr_q  <= '0;
            a_row_q   <= '0;
            b_addr_q  <= '0;
            c_addr_q  <= '0;
            rd_en_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            c_wr_en   <= 1'b0;
            c_wr_addr <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            c_wr_en   <= pipe_valid && pipe_beat.last;
            c_wr_addr <= (pipe_valid && pipe_beat.last) ? ADDR_W'(pipe_beat.c_addr) : '0;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        m_q   <= cfg_m;
                        k_q   <= cfg_k;
                        n_q   <= cfg_n;
                        busy  <= 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cfg_bad) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        i_cnt    <= '0;
                        j_cnt    <= '0;
                        k_cnt    <= '0;
                        a_addr_q <= '0;
                        a_row_q  <= '0;
                        b_addr_q <= '0;
                        c_addr_q <= '0;
                        rd_en_q  <= 1'b1;
                        first_q  <= 1'b1;
                        last_q   <= (k_q == D_ONE);
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Registers hold the beat on the bus now; compute the next one
                    first_q <= k_wrap;
                    last_q  <= k_wrap ? (k_q == D_ONE) : (k_cnt + D_TWO == k_q);
                    if (k_wrap) begin
                        k_cnt    <= '0;
                        c_addr_q <= c_addr_q + A_ONE;
                        if (j_cnt == n_q - D_ONE) begin
                            j_cnt <= '0;
                            if (i_cnt == m_q - D_ONE) begin
                                rd_en_q  <= 1'b0;
                                first_q  <= 1'b0;
                                last_q   <= 1'b0;
                                a_addr_q <= '0;
                                b_addr_q <= '0;
                                c_addr_q <= '0;
                                state    <= S_DRAIN;
                            end else begin
                                i_cnt    <= i_cnt + D_ONE;
                                a_row_q  <= a_row_q + k_q[ADDR_W-1:0];
                                a_addr_q <= a_addr_q + A_ONE;
                                b_addr_q <= '0;
                            end
                        end else begin
                            j_cnt    <= j_cnt + D_ONE;
                            a_addr_q <= a_row_q;
                            b_addr_q <= ADDR_W'(j_cnt + D_ONE);
                        end
                    end else begin
                        k_cnt    <= k_cnt + D_ONE;
                        a_addr_q <= a_addr_q + A_ONE;
                        b_addr_q <= b_addr_q + n_q[ADDR_W-1:0];
                    end
                end
                S_DRAIN: begin
                    // Once the delay line is empty the final write is on the bus this cycle
                    if (!pipe_busy) begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign beat_in.first  = first_q;
    assign beat_in.last   = last_q;
    assign beat_in.c_addr = BEAT_ADDR_W'(c_addr_q);

    matmul_beat_pipe #(
        .DEPTH(RD_LAT)
    ) u_beat_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_en_q),
        .in_beat  (beat_in),
        .out_valid(pipe_valid),
        .out_beat (pipe_beat),
        .busy     (pipe_busy)
    );

    assign a_rd_en   = rd_en_q;
    assign b_rd_en   = rd_en_q;
    assign a_rd_addr = a_addr_q;
    assign b_rd_addr = b_addr_q;
    assign mac_en    = pipe_valid;
    assign mac_first = pipe_valid & pipe_beat.first;
    assign mac_last  = pipe_valid & pipe_beat.last;

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] perf_q;

    // The accepting cycle counts as the first cycle of the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (state == S_IDLE && start) begin
            perf_q <= 32'd1;
        end else if (busy) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
